// File: rtl/servo_pkg.sv
// Shared definitions for the servo actuator axis: state encoding and
// the internal sum width used by the centre-plus-action adder.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RAILED = 2'd2
    } state_t;

    // Adder width: wide enough for either operand plus sign and carry.
    function automatic int sum_width(input int action_w, input int ftw_w);
        return ((action_w > ftw_w) ? action_w : ftw_w) + 2;
    endfunction

    localparam int SUM_WIDTH = sum_width(32, 32);

endpackage

// File: rtl/ftw_saturate.sv
// Combinational clamp of a signed sum onto the unsigned tuning-word range.
module ftw_saturate #(
    parameter int SUM_WIDTH = 34,
    parameter int FTW_WIDTH = 32
) (
    input  logic signed [SUM_WIDTH-1:0] sum,
    output logic        [FTW_WIDTH-1:0] sat,
    output logic                        sat_hi,
    output logic                        sat_lo
);

    // Negative sums clamp to zero; any set bit above the FTW range clamps high.
    always_comb begin
        sat    = sum[FTW_WIDTH-1:0];
        sat_hi = 1'b0;
        sat_lo = 1'b0;
        if (sum[SUM_WIDTH-1]) begin
            sat    = '0;
            sat_lo = 1'b1;
        end else if (|sum[SUM_WIDTH-2:FTW_WIDTH]) begin
            sat    = '1;
            sat_hi = 1'b1;
        end
    end

endmodule

// File: rtl/servo_actuator_axis.sv
// Servo actuator axis: centre FTW plus signed servo action, clamped,
// decimated and streamed to the DDS over AXI-Stream, with a rail-fault
// state machine that parks the output at the centre FTW.
module servo_actuator_axis
    import servo_pkg::*;
#(
    parameter int ACTION_WIDTH = 32,
    parameter int FTW_WIDTH    = 32,
    parameter int DECIM_WIDTH  = 16,
    parameter int RAIL_LIMIT   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [ACTION_WIDTH-1:0] action,
    input  logic [FTW_WIDTH-1:0]    ftw_center,
    input  logic [DECIM_WIDTH-1:0]  decim,
    output logic [FTW_WIDTH-1:0]    m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    rail_hi,
    output logic                    rail_lo,
    output logic                    rail_fault,
    output logic [15:0]             overrun_cnt
);

    localparam int SUM_W = sum_width(ACTION_WIDTH, FTW_WIDTH);
    localparam int RUN_W = $clog2(RAIL_LIMIT + 1);

    state_t                  state;
    logic [RUN_W-1:0]        rail_run;

    logic [DECIM_WIDTH-1:0]  cnt;
    logic [DECIM_WIDTH-1:0]  decim_q;
    logic                    tick;

    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;
    logic                    s1_valid;

    logic [FTW_WIDTH-1:0]    sat_c;
    logic                    sat_hi_c;
    logic                    sat_lo_c;
    logic [FTW_WIDTH-1:0]    sat_q;
    logic                    sat_hi_q;
    logic                    sat_lo_q;
    logic                    s2_valid;

    logic                    load_req;
    logic                    load_ok;
    logic [FTW_WIDTH-1:0]    out_word;
    logic                    out_hi;
    logic                    out_lo;

    // Tick fires on the last count of each period, only once running.
    always_comb begin
        tick = enable && (state != IDLE) && (cnt == decim_q);
    end

    // Period counter; decim is latched at each wrap and while not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            decim_q <= '0;
        end else if (!enable || state == IDLE) begin
            cnt     <= '0;
            decim_q <= decim;
        end else if (cnt == decim_q) begin
            cnt     <= '0;
            decim_q <= decim;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sign-extended action plus zero-extended centre word.
    always_comb begin
        sum_d = $signed({{(SUM_W-ACTION_WIDTH){action[ACTION_WIDTH-1]}}, action})
              + $signed({{(SUM_W-FTW_WIDTH){1'b0}}, ftw_center});
    end

    // Stage 1: capture the sum on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            sum_q    <= '0;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                sum_q <= sum_d;
            end
        end
    end

    ftw_saturate #(
        .SUM_WIDTH (SUM_W),
        .FTW_WIDTH (FTW_WIDTH)
    ) u_sat (
        .sum    (sum_q),
        .sat    (sat_c),
        .sat_hi (sat_hi_c),
        .sat_lo (sat_lo_c)
    );

    // Stage 2: register the clamped word; disabling discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sat_q    <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            s2_valid <= s1_valid && enable;
            if (s1_valid) begin
                sat_q    <= sat_c;
                sat_hi_q <= sat_hi_c;
                sat_lo_q <= sat_lo_c;
            end
        end
    end

    // Word selection: a railed axis parks at the centre with flags clear.
    always_comb begin
        load_req = s2_valid && enable;
        load_ok  = !m_axis_tvalid || m_axis_tready;
        if (state == RAILED) begin
            out_word = ftw_center;
            out_hi   = 1'b0;
            out_lo   = 1'b0;
        end else begin
            out_word = sat_q;
            out_hi   = sat_hi_q;
            out_lo   = sat_lo_q;
        end
    end

    // Output slot: load when free or being emptied this cycle, else count a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            rail_hi       <= 1'b0;
            rail_lo       <= 1'b0;
            overrun_cnt   <= '0;
        end else if (load_req && load_ok) begin
            m_axis_tdata  <= out_word;
            m_axis_tvalid <= 1'b1;
            rail_hi       <= out_hi;
            rail_lo       <= out_lo;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (load_req && overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end

    // Rail supervisor: counts consecutive saturated words in RUN, latches RAILED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rail_run <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rail_run <= '0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        rail_run <= '0;
                    end else if (load_req) begin
                        if (sat_hi_q || sat_lo_q) begin
                            rail_run <= rail_run + 1'b1;
                            if (rail_run == RUN_W'(RAIL_LIMIT - 1)) begin
                                state <= RAILED;
                            end
                        end else begin
                            rail_run <= '0;
                        end
                    end
                end
                RAILED: begin
                    if (!enable) begin
                        state    <= IDLE;
                        rail_run <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rail_run <= '0;
                end
            endcase
        end
    end

    // Fault flag mirrors the registered state.
    always_comb begin
        rail_fault = (state == RAILED);
    end

endmodule
